// File: rtl/strg_ub_affine_dp_if.sv
// Request/response bundle of the affine unified buffer: write/read requests,
// external addresses, upstream chain input and merged output with occupancy flags.
interface strg_ub_affine_dp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wen_in;
  logic                  ren_in;
  logic [CNT_WIDTH-1:0]  waddr;
  logic [CNT_WIDTH-1:0]  raddr;
  logic [DATA_WIDTH-1:0] chain_data_in;
  logic                  chain_valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;

  modport master (
    output data_in, wen_in, ren_in, waddr, raddr, chain_data_in, chain_valid_in,
    input  data_out, valid_out, full, empty
  );

  modport slave (
    input  data_in, wen_in, ren_in, waddr, raddr, chain_data_in, chain_valid_in,
    output data_out, valid_out, full, empty
  );
endinterface

// File: rtl/strg_ub_affine_dp.sv
// One-write/one-read unified buffer with external or affine (nested loop) addressing,
// occupancy-gated accepts in affine mode, 1-cycle registered read and tile chain merge.
module strg_ub_affine_dp #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 512,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int LOOP_LEVELS = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clk_en,
  input  logic                                  flush,
  input  logic                                  mode,
  input  logic [$clog2(LOOP_LEVELS):0]          wr_dim,
  input  logic [$clog2(LOOP_LEVELS):0]          rd_dim,
  input  logic [LOOP_LEVELS-1:0][CNT_WIDTH-1:0] wr_ranges,
  input  logic [LOOP_LEVELS-1:0][CNT_WIDTH-1:0] rd_ranges,
  input  logic [LOOP_LEVELS-1:0][CNT_WIDTH-1:0] wr_strides,
  input  logic [LOOP_LEVELS-1:0][CNT_WIDTH-1:0] rd_strides,
  input  logic [CNT_WIDTH-1:0]                  wr_start,
  input  logic [CNT_WIDTH-1:0]                  rd_start,
  strg_ub_affine_dp_if.slave                    bus
);
  localparam int DIM_W = $clog2(LOOP_LEVELS) + 1;

  // Port 0 is the write side, port 1 the read side; both share one iterator template.
  logic [DIM_W-1:0]                      cfg_dim    [2];
  logic [LOOP_LEVELS-1:0][CNT_WIDTH-1:0] cfg_range  [2];
  logic [LOOP_LEVELS-1:0][CNT_WIDTH-1:0] cfg_stride [2];
  logic [CNT_WIDTH-1:0]                  cfg_start  [2];
  logic [ADDR_WIDTH-1:0]                 port_addr  [2];
  logic [1:0]                            port_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   occ_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  vout_reg;
  logic                  full_int, empty_int, wacc, racc;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  unused_cfg;

  assign cfg_dim[0]    = wr_dim;
  assign cfg_dim[1]    = rd_dim;
  assign cfg_range[0]  = wr_ranges;
  assign cfg_range[1]  = rd_ranges;
  assign cfg_stride[0] = wr_strides;
  assign cfg_stride[1] = rd_strides;
  assign cfg_start[0]  = wr_start;
  assign cfg_start[1]  = rd_start;
  assign unused_cfg    = ^{wr_strides, rd_strides, wr_start, rd_start, bus.waddr, bus.raddr};

  assign full_int  = mode & (occ_reg == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_int = mode & (occ_reg == '0);
  assign racc      = bus.ren_in & (~mode | ~empty_int);
  assign wacc      = bus.wen_in & (~mode | ~full_int | racc);
  assign port_acc  = {racc, wacc};

  genvar gp, gi;
  generate
    for (gp = 0; gp < 2; gp++) begin : g_port
      logic [CNT_WIDTH-1:0]  it_val  [LOOP_LEVELS];
      logic [CNT_WIDTH-1:0]  it_next [LOOP_LEVELS];
      logic [ADDR_WIDTH-1:0] addr_sum;

      // Odometer step: the lowest level counts, each level at range-1 wraps and carries.
      // A carry out of the top active level leaves every active level at 0, i.e. back at start.
      always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < LOOP_LEVELS; i++) begin
          it_next[i] = it_val[i];
          if (DIM_W'(i) >= cfg_dim[gp]) begin
            it_next[i] = '0;
          end else if (carry) begin
            if (it_val[i] == cfg_range[gp][i] - 1'b1) begin
              it_next[i] = '0;
            end else begin
              it_next[i] = it_val[i] + 1'b1;
              carry      = 1'b0;
            end
          end
        end
      end

      // Only the low address bits matter, so the affine sum is formed modulo DEPTH directly.
      always_comb begin
        addr_sum = cfg_start[gp][ADDR_WIDTH-1:0];
        for (int i = 0; i < LOOP_LEVELS; i++) begin
          if (DIM_W'(i) < cfg_dim[gp]) begin
            addr_sum = addr_sum + it_val[i][ADDR_WIDTH-1:0] * cfg_stride[gp][i][ADDR_WIDTH-1:0];
          end
        end
      end
      assign port_addr[gp] = addr_sum;

      for (gi = 0; gi < LOOP_LEVELS; gi++) begin : g_lvl
        logic [CNT_WIDTH-1:0] it_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            it_reg <= '0;
          end else if (clk_en) begin
            if (flush) it_reg <= '0;
            else if (mode && port_acc[gp]) it_reg <= it_next[gi];
          end
        end
        assign it_val[gi] = it_reg;
      end
    end
  endgenerate

  assign wr_addr = mode ? port_addr[0] : bus.waddr[ADDR_WIDTH-1:0];
  assign rd_addr = mode ? port_addr[1] : bus.raddr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (clk_en && !flush && wacc) mem[wr_addr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else if (clk_en) begin
      if (flush) begin
        occ_reg <= '0;
      end else if (mode) begin
        if (wacc && !racc) occ_reg <= occ_reg + 1'b1;
        else if (racc && !wacc) occ_reg <= occ_reg - 1'b1;
      end
    end
  end

  // Non-blocking read of mem gives the pre-write word on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
      vout_reg <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        dout_reg <= '0;
        vout_reg <= 1'b0;
      end else begin
        vout_reg <= racc;
        if (racc) dout_reg <= mem[rd_addr];
      end
    end
  end

  assign bus.data_out  = vout_reg ? dout_reg : bus.chain_data_in;
  assign bus.valid_out = vout_reg | bus.chain_valid_in;
  assign bus.full      = full_int;
  assign bus.empty     = empty_int;
endmodule

// File: tb/tb_strg_ub_affine_dp.sv
// Randomised and directed checks of strg_ub_affine_dp (DEPTH 512 and DEPTH 4 instances)
// against a counter/array model that derives affine addresses by digit decomposition.
module tb_strg_ub_affine_dp;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int LL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clk_en, flush, mode;
  logic [2:0] wr_dim, rd_dim;
  logic [LL-1:0][CW-1:0] wr_ranges, rd_ranges, wr_strides, rd_strides;
  logic [CW-1:0] wr_start, rd_start;

  strg_ub_affine_dp_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus0 ();
  strg_ub_affine_dp_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus1 ();

  strg_ub_affine_dp #(.DATA_WIDTH(DW), .DEPTH(512), .LOOP_LEVELS(LL), .CNT_WIDTH(CW)) u_big (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .mode(mode),
    .wr_dim(wr_dim), .rd_dim(rd_dim), .wr_ranges(wr_ranges), .rd_ranges(rd_ranges),
    .wr_strides(wr_strides), .rd_strides(rd_strides), .wr_start(wr_start), .rd_start(rd_start),
    .bus(bus0)
  );

  strg_ub_affine_dp #(.DATA_WIDTH(DW), .DEPTH(4), .LOOP_LEVELS(LL), .CNT_WIDTH(CW)) u_small (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .mode(mode),
    .wr_dim(wr_dim), .rd_dim(rd_dim), .wr_ranges(wr_ranges), .rd_ranges(rd_ranges),
    .wr_strides(wr_strides), .rd_strides(rd_strides), .wr_start(wr_start), .rd_start(rd_start),
    .bus(bus1)
  );

  // Reference model state, indexed by unit (0 = DEPTH 512, 1 = DEPTH 4)
  int          n_checks = 0;
  int          n_fail   = 0;
  int          depth_m [2] = '{512, 4};
  logic [15:0] mem_m   [2][512];
  int          occ_m   [2];
  longint      wcnt    [2];
  longint      rcnt    [2];
  logic [15:0] dreg_m  [2];
  logic        vreg_m  [2];
  logic        cv_m;
  logic [15:0] cd_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address of the cnt-th transfer: decompose cnt into mixed-radix digits of the ranges.
  function automatic int aff_addr(input longint cnt, input logic [2:0] dim,
                                  input logic [LL-1:0][CW-1:0] rng, input logic [LL-1:0][CW-1:0] str,
                                  input logic [CW-1:0] start, input int depth);
    longint period, idx, a;
    period = 1;
    for (int i = 0; i < int'(dim); i++) period = period * longint'(rng[i]);
    idx = cnt % period;
    a   = longint'(start);
    for (int i = 0; i < int'(dim); i++) begin
      a   = a + (idx % longint'(rng[i])) * longint'(str[i]);
      idx = idx / longint'(rng[i]);
    end
    return int'(a % longint'(depth));
  endfunction

  task automatic drive(input int u, input logic w, input logic r, input logic [15:0] d,
                       input logic [15:0] wa, input logic [15:0] ra, input logic cv, input logic [15:0] cd);
    bus0.wen_in = (u == 0) && w;  bus0.ren_in = (u == 0) && r;
    bus0.data_in = d;  bus0.waddr = wa;  bus0.raddr = ra;
    bus0.chain_valid_in = (u == 0) && cv;  bus0.chain_data_in = (u == 0) ? cd : 16'h0;
    bus1.wen_in = (u == 1) && w;  bus1.ren_in = (u == 1) && r;
    bus1.data_in = d;  bus1.waddr = wa;  bus1.raddr = ra;
    bus1.chain_valid_in = (u == 1) && cv;  bus1.chain_data_in = (u == 1) ? cd : 16'h0;
    cv_m = cv;
    cd_m = cd;
  endtask

  task automatic sample(input int u, output logic [15:0] d, output logic v, output logic f, output logic e);
    if (u == 0) begin d = bus0.data_out; v = bus0.valid_out; f = bus0.full; e = bus0.empty; end
    else        begin d = bus1.data_out; v = bus1.valid_out; f = bus1.full; e = bus1.empty; end
  endtask

  task automatic check_outs(input int u);
    logic [15:0] d;
    logic v, f, e, cv;
    logic [15:0] cd;
    sample(u, d, v, f, e);
    cv = (u == 0) ? bus0.chain_valid_in : bus1.chain_valid_in;
    cd = (u == 0) ? bus0.chain_data_in : bus1.chain_data_in;
    check($sformatf("u%0d data_out", u), 32'(d), 32'(vreg_m[u] ? dreg_m[u] : cd));
    check($sformatf("u%0d valid_out", u), 32'(v), 32'(vreg_m[u] | cv));
    check($sformatf("u%0d full", u), 32'(f), 32'(mode && occ_m[u] == depth_m[u]));
    check($sformatf("u%0d empty", u), 32'(e), 32'(mode && occ_m[u] == 0));
  endtask

  task automatic cycle(input int u, input logic w, input logic r, input logic [15:0] d,
                       input logic [15:0] wa, input logic [15:0] ra,
                       input logic cv = 1'b0, input logic [15:0] cd = 16'h0);
    logic fm, em, racc, wacc;
    int wad, rad;
    logic [15:0] rdat;
    drive(u, w, r, d, wa, ra, cv, cd);
    fm   = mode && occ_m[u] == depth_m[u];
    em   = mode && occ_m[u] == 0;
    racc = r && (!mode || !em);
    wacc = w && (!mode || !fm || racc);
    wad  = mode ? aff_addr(wcnt[u], wr_dim, wr_ranges, wr_strides, wr_start, depth_m[u]) : int'(wa) % depth_m[u];
    rad  = mode ? aff_addr(rcnt[u], rd_dim, rd_ranges, rd_strides, rd_start, depth_m[u]) : int'(ra) % depth_m[u];
    @(posedge clk);
    #1;
    if (clk_en) begin
      rdat = mem_m[u][rad];
      if (wacc) mem_m[u][wad] = d;
      vreg_m[u]   = racc;
      vreg_m[1-u] = 1'b0;
      if (racc) dreg_m[u] = rdat;
      if (mode) begin
        if (wacc) wcnt[u]++;
        if (racc) rcnt[u]++;
        if (wacc && !racc) occ_m[u]++;
        else if (racc && !wacc) occ_m[u]--;
      end
    end
    $display("u%0d en=%0b mode=%0b wen=%0b ren=%0b din=%h wacc=%0b racc=%0b occ=%0d",
             u, clk_en, mode, w, r, d, wacc, racc, occ_m[u]);
    check_outs(u);
  endtask

  task automatic clear_model(input logic full_reset);
    for (int u = 0; u < 2; u++) begin
      occ_m[u] = 0; wcnt[u] = 0; rcnt[u] = 0; vreg_m[u] = 1'b0; dreg_m[u] = 16'h0;
      if (full_reset) begin end
    end
  endtask

  task automatic flush_cycle(input logic en);
    drive(-1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
    flush  = 1'b1;
    clk_en = en;
    @(posedge clk);
    #1;
    if (en) clear_model(1'b0);
    flush  = 1'b0;
    clk_en = 1'b1;
    $display("flush clk_en=%0b", en);
    check_outs(0);
    check_outs(1);
  endtask

  task automatic async_reset();
    drive(-1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model(1'b1);
    $display("async reset asserted");
    check_outs(0);
    check_outs(1);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_affine(input logic [2:0] dim, input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] st);
    wr_dim = dim; wr_ranges = '0; wr_strides = '0; wr_start = st;
    wr_ranges[0] = r0; wr_ranges[1] = r1; wr_ranges[2] = 16'd1;
    wr_strides[0] = s0; wr_strides[1] = s1;
    rd_dim = wr_dim; rd_ranges = wr_ranges; rd_strides = wr_strides; rd_start = wr_start;
  endtask

  task automatic rand_seg(input int u, input int n);
    wr_dim = 3'($urandom_range(1, 3));
    rd_dim = 3'($urandom_range(1, 3));
    for (int i = 0; i < LL; i++) begin
      wr_ranges[i]  = 16'($urandom_range(1, 4));
      rd_ranges[i]  = 16'($urandom_range(1, 4));
      wr_strides[i] = 16'($urandom_range(0, 15));
      rd_strides[i] = 16'($urandom_range(0, 15));
    end
    wr_start = 16'($urandom);
    rd_start = 16'($urandom);
    mode = 1'b1;
    flush_cycle(1'b1);
    for (int k = 0; k < n; k++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      cycle(u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'h0, 16'h0,
            1'($urandom_range(0, 7) == 0), 16'($urandom));
    end
    clk_en = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    logic v, f, e;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; mode = 1'b1;
    set_affine(3'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0);
    drive(-1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
    clear_model(1'b1);
    #12;
    check_outs(0);
    check_outs(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill both memories with known data through external addressing
    mode = 1'b0;
    for (int a = 0; a < 512; a++) cycle(0, 1, 0, 16'($urandom), 16'(a), 16'h0);
    for (int a = 0; a < 4; a++)   cycle(1, 1, 0, 16'($urandom), 16'(a), 16'h0);

    // External mode, truncation and read-before-write
    cycle(0, 1, 0, 16'hA5A5, 16'd7, 16'd0);
    cycle(0, 0, 1, 16'h0, 16'd0, 16'd7);
    sample(0, d, v, f, e);
    check("ext_read_a5a5", 32'(d), 32'h0000A5A5);
    cycle(0, 1, 0, 16'h5A5A, 16'd519, 16'd0);
    cycle(0, 0, 1, 16'h0, 16'd0, 16'd7);
    sample(0, d, v, f, e);
    check("ext_trunc_519", 32'(d), 32'h00005A5A);
    cycle(0, 1, 1, 16'h1111, 16'd7, 16'd7);
    sample(0, d, v, f, e);
    check("ext_rbw_old", 32'(d), 32'h00005A5A);
    cycle(0, 1, 0, 16'h5A5A, 16'd7, 16'd0);

    // Affine dim 2, ranges {4,3}, strides {1,8}
    mode = 1'b1;
    set_affine(3'd2, 16'd4, 16'd3, 16'd1, 16'd8, 16'd0);
    flush_cycle(1'b1);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 16'(i), 16'h0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 16'h0, 16'h0, 16'h0);
      sample(0, d, v, f, e);
      check("aff_seq_data", 32'(d), 32'(i));
      check("aff_seq_valid", 32'(v), 32'd1);
    end
    cycle(0, 1, 0, 16'hBEEF, 16'h0, 16'h0);
    mode = 1'b0;
    cycle(0, 0, 1, 16'h0, 16'h0, 16'd0);
    sample(0, d, v, f, e);
    check("aff_wrap_addr0", 32'(d), 32'h0000BEEF);
    cycle(0, 0, 1, 16'h0, 16'h0, 16'd16);
    sample(0, d, v, f, e);
    check("aff_addr16", 32'(d), 32'd8);

    // DEPTH 4 full/empty gating
    mode = 1'b1;
    set_affine(3'd1, 16'd4, 16'd1, 16'd1, 16'd0, 16'd0);
    flush_cycle(1'b1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 16'(16'h40 + i), 16'h0, 16'h0);
    sample(1, d, v, f, e);
    check("d4_full", 32'(f), 32'd1);
    cycle(1, 1, 0, 16'hDEAD, 16'h0, 16'h0);
    sample(1, d, v, f, e);
    check("d4_drop_full", 32'(f), 32'd1);
    cycle(1, 1, 1, 16'h0050, 16'h0, 16'h0);
    sample(1, d, v, f, e);
    check("d4_both_full", 32'(f), 32'd1);
    check("d4_both_data", 32'(d), 32'h00000040);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 16'h0, 16'h0, 16'h0);
    cycle(1, 0, 1, 16'h0, 16'h0, 16'h0);
    sample(1, d, v, f, e);
    check("d4_empty_novalid", 32'(v), 32'd0);
    check("d4_empty", 32'(e), 32'd1);

    // Chain merge
    mode = 1'b0;
    cycle(0, 0, 0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h1234);
    sample(0, d, v, f, e);
    check("chain_pass_data", 32'(d), 32'h00001234);
    check("chain_pass_valid", 32'(v), 32'd1);
    cycle(0, 0, 1, 16'h0, 16'h0, 16'd7, 1'b1, 16'h1234);
    sample(0, d, v, f, e);
    check("chain_local_wins", 32'(d), 32'h00005A5A);

    // Mid-pattern async reset, then flush behaviour
    mode = 1'b1;
    set_affine(3'd2, 16'd4, 16'd3, 16'd1, 16'd8, 16'd5);
    flush_cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 16'(100 + i), 16'h0, 16'h0);
    async_reset();
    sample(0, d, v, f, e);
    check("rst_empty", 32'(e), 32'd1);
    check("rst_valid", 32'(v), 32'd0);
    cycle(0, 1, 0, 16'h7777, 16'h0, 16'h0);
    cycle(0, 0, 1, 16'h0, 16'h0, 16'h0);
    sample(0, d, v, f, e);
    check("rst_write_at_start", 32'(d), 32'h00007777);
    cycle(0, 1, 0, 16'h0101, 16'h0, 16'h0);
    cycle(0, 1, 0, 16'h0202, 16'h0, 16'h0);
    flush_cycle(1'b0);
    sample(0, d, v, f, e);
    check("flush_gated_hold", 32'(e), 32'd0);
    flush_cycle(1'b1);
    sample(0, d, v, f, e);
    check("flush_empty", 32'(e), 32'd1);
    mode = 1'b0;
    cycle(0, 0, 1, 16'h0, 16'h0, 16'd6);
    sample(0, d, v, f, e);
    check("flush_mem_kept", 32'(d), 32'h00000101);

    // Randomised affine traffic on both depths
    for (int s = 0; s < 4; s++) rand_seg(s % 2, 250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/strg_ub_affine_dp.md
Name: strg_ub_affine_dp

Overview:
- Parametrised successor to the thin dual-port unified buffer.
- Wraps a DEPTH x DATA_WIDTH one-write/one-read memory.
- Two address modes:
  - External: address ports drive the memory directly.
  - Affine: internal multi-level loop iterators generate write and read addresses.
- In affine mode, occupancy tracking gates reads when empty and writes when full.
- The read path is registered with a valid flag and merged with the upstream tile chain.

Parameters:
DATA_WIDTH, 16, word width
DEPTH, 512, memory words (power of two)
ADDR_WIDTH, $clog2(DEPTH), memory address width
LOOP_LEVELS, 3, affine iterator levels per port
CNT_WIDTH, 16, width of iterator ranges/strides/start/external addresses

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global clock enable; low = all state holds
flush  in  1  synchronous soft reset, qualified by clk_en
mode  in  1  0 = EXTERNAL, 1 = AFFINE (static config)
data_in  in  DATA_WIDTH  write data
wen_in  in  1  write request
ren_in  in  1  read request
waddr  in  CNT_WIDTH  external write address (mode 0)
raddr  in  CNT_WIDTH  external read address (mode 0)
wr_dim, rd_dim  in  $clog2(LOOP_LEVELS)+1 each  active iterator levels, 1..LOOP_LEVELS
wr_ranges, rd_ranges  in  LOOP_LEVELS x CNT_WIDTH  per-level extent (>=1)
wr_strides, rd_strides  in  LOOP_LEVELS x CNT_WIDTH  per-level stride
wr_start, rd_start  in  CNT_WIDTH  base address
chain_data_in  in  DATA_WIDTH  upstream tile data
chain_valid_in  in  1  upstream tile valid
data_out  out  DATA_WIDTH  merged output data
valid_out  out  1  merged output valid
full  out  1  occupancy == DEPTH (mode 1)
empty  out  1  occupancy == 0 (mode 1)

Behaviour:
- Reset (rst_n low, async):
  - data_out=0, valid_out_int=0.
  - All iterators 0; occupancy 0.
  - full=0, empty=1.
  - Memory contents undefined.
- flush (with clk_en) clears the same state synchronously. Memory contents are preserved.
- Accept rules:
  - Write accepted: wacc = wen_in & (mode==0 | ~full | racc).
  - Read accepted: racc = ren_in & (mode==0 | ~empty).
  - Rejected requests are dropped silently and never retried.
- Write/read addresses:
  - mode 0: waddr[ADDR_WIDTH-1:0] and raddr[ADDR_WIDTH-1:0].
  - mode 1: addr = (start + sum over i<dim of it[i]*stride[i]) mod DEPTH, taken from current iterator values; levels >= dim contribute 0.
- Iterator step (per port, on accept, mode 1 only):
  - Level 0 increments.
  - A level at range-1 wraps to 0 and carries to the next level.
  - Carry out of level dim-1 wraps the whole pattern to start, so the pattern repeats indefinitely.
  - range==1 levels always carry.
- Occupancy (mode 1):
  - +1 on wacc only, -1 on racc only.
  - Unchanged on simultaneous accept.
  - Width ADDR_WIDTH+1; saturation is impossible by the accept rules.
  - In mode 0 occupancy holds 0, and full/empty are forced to 0.
- Memory:
  - The write commits at the clock edge.
  - A read to the same address in the same cycle returns the OLD data (read-before-write).
- Read latency is 1 cycle:
  - data_out_int is registered from the memory on racc.
  - valid_out_int <= racc.
  - data_out_int holds when there is no racc.
- Chain merge (combinational):
  - data_out = valid_out_int ? data_out_int : chain_data_in.
  - valid_out = valid_out_int | chain_valid_in.
- clk_en low: no accepts take effect; iterators, occupancy and output registers hold; the chain merge still passes through.
- Config ports are static while clk_en is high; changing them mid-pattern is undefined.

Test Plan:
- Mode 0, DEPTH 512: write 0xA5A5 @ waddr 7, then ren @ raddr 7 -> the cycle after the read, data_out=0xA5A5, valid_out=1. Repeat with waddr 519 -> write lands at address 7 (truncation).
- Mode 1, dim=2, wr/rd ranges {4,3}, strides {1,8}, start 0:
  - Write 12 words 0..11, then read 12 -> addresses 0,1,2,3,8,9,10,11,16..19 on both ports.
  - data_out sequence 0..11 with 1-cycle latency.
  - The 13th write goes to address 0 (pattern wrap).
- Mode 1, DEPTH 4:
  - Write 4 words -> full=1.
  - 5th wen alone is dropped, occupancy stays 4.
  - wen+ren in the same cycle -> both accepted, full stays 1.
  - ren on empty -> no valid_out.
- Chain: no local read, chain_valid_in=1, chain_data_in=0x1234 -> data_out=0x1234, valid_out=1. Local read valid the same cycle -> local data wins.
- Mid-pattern async reset, then flush:
  - Async rst_n low after 5 writes -> empty=1, valid_out=0, iterators 0; the next write lands at start.
  - flush with clk_en=0 has no effect; flush with clk_en=1 clears occupancy, and memory data written before remains readable via mode 0.
